// File: rtl/glitch_sequencer_if.sv
// Bundle between the glitch sequencer and its environment: controls, tick, trigger,
// program ROM read port and the parallel output pattern.
interface glitch_sequencer_if #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned DELAY_W = 32
);
    logic               start;
    logic               abort;
    logic [ADDR_W-1:0]  start_addr;
    logic               tick;
    logic               trigger;
    logic [ADDR_W-1:0]  rom_addr;
    logic [11:0]        rom_instr;
    logic [DELAY_W-1:0] rom_delay;
    logic [7:0]         parallel_out;
    logic               busy;
    logic               done;

    // Sequencer side.
    modport master (
        input  start, abort, start_addr, tick, trigger, rom_instr, rom_delay,
        output rom_addr, parallel_out, busy, done
    );

    // Environment side: controls, clock divider and ROM.
    modport slave (
        output start, abort, start_addr, tick, trigger, rom_instr, rom_delay,
        input  rom_addr, parallel_out, busy, done
    );
endinterface

// File: rtl/glitch_sequencer.sv
// Instruction sequencer for the glitch test interface: walks the program ROM, drives
// the parallel output pattern and times each OUT in divider ticks.
module glitch_sequencer #(
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned DELAY_W  = 32,
    parameter logic [7:0]  IDLE_OUT = 8'h00
) (
    input  logic              clk,
    input  logic              reset,
    glitch_sequencer_if.master bus
);

    typedef enum logic [1:0] {StIdle, StFetch, StDelay, StTrig} state_e;

    localparam logic [2:0] OpOut  = 3'b000;
    localparam logic [2:0] OpJump = 3'b001;
    localparam logic [2:0] OpHalt = 3'b010;
    localparam logic [2:0] OpWait = 3'b011;

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [7:0]         out_q, out_d;
    logic [DELAY_W-1:0] cnt_q, cnt_d;
    logic               done_q, done_d;

    logic [2:0]         opcode;
    logic [7:0]         data;
    logic [ADDR_W-1:0]  addr_inc;
    logic               unused_rsvd;

    assign opcode      = bus.rom_instr[11:9];
    assign data        = bus.rom_instr[8:1];
    assign addr_inc    = addr_q + ADDR_W'(1);
    // Bit 0 of the instruction is reserved.
    assign unused_rsvd = bus.rom_instr[0];

    // State and datapath registers; async reset to the idle condition.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            addr_q  <= '0;
            out_q   <= IDLE_OUT;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            out_q   <= out_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    // Next-state decode; abort overrides every other condition.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        out_d   = out_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;

        if (bus.abort) begin
            // rom_addr deliberately keeps its last value.
            state_d = StIdle;
            out_d   = IDLE_OUT;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        addr_d  = bus.start_addr;
                        out_d   = IDLE_OUT;
                        state_d = StFetch;
                    end
                end
                StFetch: begin
                    unique casez (opcode)
                        OpOut: begin
                            out_d = data;
                            if (bus.rom_delay == '0) begin
                                addr_d = addr_inc;
                            end else begin
                                cnt_d   = bus.rom_delay;
                                state_d = StDelay;
                            end
                        end
                        OpJump: addr_d = ADDR_W'(data);
                        OpHalt: begin
                            done_d  = 1'b1;
                            state_d = StIdle;
                        end
                        OpWait: begin
                            out_d   = data;
                            state_d = StTrig;
                        end
                        3'b1??: addr_d = addr_inc;
                        default: ;
                    endcase
                end
                StDelay: begin
                    if (bus.tick) begin
                        cnt_d = cnt_q - DELAY_W'(1);
                        if (cnt_q == DELAY_W'(1)) begin
                            addr_d  = addr_inc;
                            state_d = StFetch;
                        end
                    end
                end
                StTrig: begin
                    if (bus.trigger) begin
                        addr_d  = addr_inc;
                        state_d = StFetch;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // All outputs come straight from registers.
    always_comb begin
        bus.rom_addr     = addr_q;
        bus.parallel_out = out_q;
        bus.busy         = (state_q != StIdle);
        bus.done         = done_q;
    end

endmodule

// File: tb/tb_glitch_sequencer.sv
// Directed bench for glitch_sequencer: a vector table for the basic OUT/HALT flow
// plus hand-written sequences for tick pacing, jump loops, wrap, trigger and reset.
module tb_glitch_sequencer;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    glitch_sequencer_if #(.ADDR_W(8), .DELAY_W(32)) bus ();

    glitch_sequencer #(
        .ADDR_W  (8),
        .DELAY_W (32),
        .IDLE_OUT(8'h00)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    logic [11:0] rom_i [256];
    logic [31:0] rom_d [256];
    assign bus.rom_instr = rom_i[bus.rom_addr];
    assign bus.rom_delay = rom_d[bus.rom_addr];

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [11:0] IHalt = 12'h400;
    localparam logic [11:0] INop  = 12'h800;

    function automatic logic [11:0] i_out(input logic [7:0] d);
        return {3'b000, d, 1'b0};
    endfunction
    function automatic logic [11:0] i_jmp(input logic [7:0] d);
        return {3'b001, d, 1'b0};
    endfunction
    function automatic logic [11:0] i_wait(input logic [7:0] d);
        return {3'b011, d, 1'b0};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) begin
            rom_i[i] = IHalt;
            rom_d[i] = 32'd0;
        end
    endtask

    task automatic do_reset();
        bus.start = 1'b0; bus.abort = 1'b0; bus.tick = 1'b1; bus.trigger = 1'b0;
        bus.start_addr = 8'h00;
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    typedef struct {
        logic       start;
        logic       abort;
        logic [7:0] addr;
        logic [7:0] pout;
        logic       busy;
        logic       done;
    } vec_t;

    vec_t tbl [10];
    int   cnt;
    logic seen_done;

    initial begin
        // Basic program: OUT A5 for 3 ticks, then HALT; tick every cycle.
        tbl[0] = '{1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0};
        tbl[1] = '{1'b0, 1'b0, 8'h00, 8'hA5, 1'b1, 1'b0};
        tbl[2] = '{1'b0, 1'b0, 8'h00, 8'hA5, 1'b1, 1'b0};
        tbl[3] = '{1'b0, 1'b0, 8'h00, 8'hA5, 1'b1, 1'b0};
        tbl[4] = '{1'b0, 1'b0, 8'h01, 8'hA5, 1'b1, 1'b0};
        tbl[5] = '{1'b0, 1'b0, 8'h01, 8'hA5, 1'b0, 1'b1};
        tbl[6] = '{1'b0, 1'b0, 8'h01, 8'hA5, 1'b0, 1'b0};
        tbl[7] = '{1'b0, 1'b1, 8'h01, 8'h00, 1'b0, 1'b0};
        tbl[8] = '{1'b1, 1'b1, 8'h01, 8'h00, 1'b0, 1'b0};
        tbl[9] = '{1'b0, 1'b0, 8'h01, 8'h00, 1'b0, 1'b0};

        clear_rom();
        rom_i[0] = i_out(8'hA5); rom_d[0] = 32'd3;
        rom_i[1] = IHalt;
        do_reset();
        chk("reset_addr", bus.rom_addr, 0);
        chk("reset_out", bus.parallel_out, 8'h00);
        chk("reset_busy", bus.busy, 0);
        chk("reset_done", bus.done, 0);

        for (int i = 0; i < 10; i++) begin
            bus.start = tbl[i].start;
            bus.abort = tbl[i].abort;
            step();
            chk($sformatf("tbl%0d_addr", i), bus.rom_addr, tbl[i].addr);
            chk($sformatf("tbl%0d_out", i), bus.parallel_out, tbl[i].pout);
            chk($sformatf("tbl%0d_busy", i), bus.busy, tbl[i].busy);
            chk($sformatf("tbl%0d_done", i), bus.done, tbl[i].done);
        end
        bus.start = 1'b0; bus.abort = 1'b0;

        // Tick every 4th cycle: A5 visible for 12 busy cycles before done.
        do_reset();
        bus.start = 1'b1; step(); bus.start = 1'b0;
        cnt = 0; seen_done = 1'b0;
        for (int ph = 0; ph < 40 && !seen_done; ph++) begin
            bus.tick = (ph % 4 == 3);
            step();
            if (bus.busy && bus.parallel_out == 8'hA5) cnt++;
            if (bus.done) seen_done = 1'b1;
        end
        chk("slow_tick_cycles", cnt, 12);
        chk("slow_tick_done", seen_done, 1);

        // Zero delay: the OUT lasts exactly its fetch cycle.
        rom_d[0] = 32'd0;
        do_reset();
        bus.start = 1'b1; step(); bus.start = 1'b0;
        cnt = 0; seen_done = 1'b0;
        for (int k = 0; k < 10 && !seen_done; k++) begin
            step();
            if (bus.busy && bus.parallel_out == 8'hA5) cnt++;
            if (bus.done) seen_done = 1'b1;
        end
        chk("zero_delay_cycles", cnt, 1);
        chk("zero_delay_done", seen_done, 1);

        // OUT 01 d1 / JUMP 0 loop, then abort while holding in DELAY.
        clear_rom();
        rom_i[0] = i_out(8'h01); rom_d[0] = 32'd1;
        rom_i[1] = i_jmp(8'h00);
        do_reset();
        bus.start = 1'b1; step(); bus.start = 1'b0;
        for (int i = 0; i < 9; i++) begin
            step();
            chk($sformatf("loop%0d_addr", i), bus.rom_addr, (i % 3 == 1) ? 1 : 0);
            chk($sformatf("loop%0d_out", i), bus.parallel_out, 8'h01);
            chk($sformatf("loop%0d_busy", i), bus.busy, 1);
        end
        bus.tick = 1'b0;
        step(); step();
        chk("hold_busy", bus.busy, 1);
        bus.abort = 1'b1;
        step();
        chk("abort_out", bus.parallel_out, 8'h00);
        chk("abort_busy", bus.busy, 0);
        chk("abort_done", bus.done, 0);
        chk("abort_addr", bus.rom_addr, 0);
        bus.abort = 1'b0;
        step();
        chk("abort_done_after", bus.done, 0);
        chk("abort_idle_after", bus.busy, 0);

        // Address wrap: NOP at FF falls through to HALT at 00.
        clear_rom();
        rom_i[8'hFF] = INop;
        rom_i[0]     = IHalt;
        do_reset();
        bus.start_addr = 8'hFF;
        bus.start = 1'b1; step(); bus.start = 1'b0;
        chk("wrap_start_addr", bus.rom_addr, 8'hFF);
        step();
        chk("wrap_addr", bus.rom_addr, 8'h00);
        chk("wrap_busy", bus.busy, 1);
        step();
        chk("wrap_done", bus.done, 1);
        chk("wrap_busy_low", bus.busy, 0);

        // WAIT_TRIG: hold 3C until trigger, done two cycles after it.
        clear_rom();
        rom_i[0] = i_wait(8'h3C);
        rom_i[1] = IHalt;
        do_reset();
        bus.start = 1'b1; step(); bus.start = 1'b0;
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (bus.parallel_out == 8'h3C && bus.busy && bus.rom_addr == 8'h00 && !bus.done)
                cnt++;
        end
        chk("trig_hold_cycles", cnt, 20);
        bus.trigger = 1'b1;
        step();
        bus.trigger = 1'b0;
        chk("trig_advance_addr", bus.rom_addr, 1);
        chk("trig_advance_done", bus.done, 0);
        chk("trig_out", bus.parallel_out, 8'h3C);
        step();
        chk("trig_done", bus.done, 1);

        // Asynchronous reset in the middle of a delay.
        clear_rom();
        rom_i[5] = i_out(8'hA5); rom_d[5] = 32'd3;
        do_reset();
        bus.tick = 1'b0;
        bus.start_addr = 8'h05;
        bus.start = 1'b1; step(); bus.start = 1'b0;
        step();
        chk("pre_rst_out", bus.parallel_out, 8'hA5);
        chk("pre_rst_addr", bus.rom_addr, 8'h05);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_addr", bus.rom_addr, 0);
        chk("async_rst_out", bus.parallel_out, 8'h00);
        chk("async_rst_busy", bus.busy, 0);
        chk("async_rst_done", bus.done, 0);
        @(negedge clk);
        reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
